// File: rtl/rsa_pkg.sv
// Shared types and width for the RSA datapath (inverse stage and modexp).
package rsa_pkg;

  localparam int unsigned RSA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    MULT   = 2'd2,
    FIN    = 2'd3
  } modexp_state_t;

  typedef enum logic {
    MM_IDLE = 1'b0,
    MM_RUN  = 1'b1
  } mm_state_t;

endpackage

// File: rtl/mod_mult.sv
// Bit-serial interleaved modular multiplier: p = a*b mod n, MSB of a first.
// Requires b < n; one launch cycle, W iteration cycles, done on the last.
module mod_mult
  import rsa_pkg::*;
#(
  parameter int unsigned W = RSA_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] n,
  output logic [W-1:0] p,
  output logic         done
);

  localparam int unsigned AW = W + 2;
  localparam int unsigned CW = $clog2(W);

  mm_state_t       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, n_q, n_d, p_q, p_d;
  logic            done_q, done_d;
  logic [AW-1:0]   n_ext, t0, t1, t2;

  // Step: double, add b on a set bit, then up to two subtractions of n.
  always_comb begin
    n_ext = AW'(n_q);
    t0    = (acc_q << 1) + (a_q[cnt_q] ? AW'(b_q) : AW'(0));
    t1    = (t0 >= n_ext) ? (t0 - n_ext) : t0;
    t2    = (t1 >= n_ext) ? (t1 - n_ext) : t1;
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    n_d     = n_q;
    p_d     = p_q;
    done_d  = 1'b0;
    case (state_q)
      MM_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          n_d     = n;
          acc_d   = '0;
          cnt_d   = CW'(W - 1);
          state_d = MM_RUN;
        end
      end
      MM_RUN: begin
        acc_d = t2;
        if (cnt_q == CW'(0)) begin
          p_d     = t2[W-1:0];
          done_d  = 1'b1;
          state_d = MM_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = MM_IDLE;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= MM_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      n_q     <= '0;
      p_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      n_q     <= n_d;
      p_q     <= p_d;
      done_q  <= done_d;
    end
  end

  assign p    = p_q;
  assign done = done_q;

endmodule

// File: rtl/rsa_modexp.sv
// Modular exponentiation, right-to-left square-and-multiply.
// mm_r carries the running result (and the initial base reduction),
// mm_b squares the base; both run in lockstep each exponent bit.
module rsa_modexp
  import rsa_pkg::*;
#(
  parameter int unsigned W = RSA_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [W-1:0] base,
  input  logic [W-1:0] exponent,
  input  logic [W-1:0] modulus,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         error
);

  modexp_state_t state_q, state_d;
  logic [W-1:0]  e_q, e_d, r_q, r_d, b_q, b_d, n_q, n_d, result_q, result_d;
  logic          err_q, err_d, busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic          go_r, go_b, done_r, done_b;
  logic [W-1:0]  op_a, op_b, op_n, p_r, p_b;

  mod_mult #(.W(W)) mm_r (
    .clk(clk), .reset_n(reset_n), .start(go_r),
    .a(op_a), .b(op_b), .n(op_n), .p(p_r), .done(done_r)
  );

  mod_mult #(.W(W)) mm_b (
    .clk(clk), .reset_n(reset_n), .start(go_b),
    .a(b_d), .b(b_d), .n(n_q), .p(p_b), .done(done_b)
  );

  // Sequencing: a finishing multiply relaunches in the same edge it is consumed.
  always_comb begin
    state_d  = state_q;
    e_d      = e_q;
    r_d      = r_q;
    b_d      = b_q;
    n_d      = n_q;
    err_d    = err_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    error_d  = error_q;
    go_r     = 1'b0;
    go_b     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          e_d     = exponent;
          n_d     = modulus;
          error_d = 1'b0;
          if (modulus == W'(0)) begin
            r_d     = '0;
            err_d   = 1'b1;
            state_d = FIN;
          end else if (modulus == W'(1)) begin
            r_d     = '0;
            err_d   = 1'b0;
            state_d = FIN;
          end else begin
            r_d     = W'(1);
            err_d   = 1'b0;
            busy_d  = 1'b1;
            go_r    = 1'b1;
            state_d = REDUCE;
          end
        end
      end
      REDUCE: begin
        if (done_r) begin
          b_d = p_r;
          if (e_q == W'(0)) begin
            state_d = FIN;
          end else begin
            state_d = MULT;
            go_b    = 1'b1;
            go_r    = e_q[0];
          end
        end
      end
      MULT: begin
        if (done_b) begin
          b_d = p_b;
          if (e_q[0]) r_d = p_r;
          e_d = e_q >> 1;
          if (e_d == W'(0)) begin
            state_d = FIN;
          end else begin
            go_b = 1'b1;
            go_r = e_d[0];
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Outputs of the finished operation appear together with entry into FIN.
    if (state_d == FIN && state_q != FIN) begin
      done_d   = 1'b1;
      busy_d   = 1'b0;
      result_d = r_d;
      error_d  = err_d;
    end
    // Base reduction takes operands straight from the ports.
    if (state_q == IDLE) begin
      op_a = base;
      op_b = W'(1);
      op_n = modulus;
    end else begin
      op_a = r_d;
      op_b = b_d;
      op_n = n_q;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      e_q      <= '0;
      r_q      <= '0;
      b_q      <= '0;
      n_q      <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      e_q      <= e_d;
      r_q      <= r_d;
      b_q      <= b_d;
      n_q      <= n_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      error_q  <= error_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign error  = error_q;

endmodule

// File: tb/tb_rsa_modexp.sv
// Self-checking bench for rsa_modexp: arithmetic reference model plus
// cycle-accurate expectations for busy/done/result/error.
module tb_rsa_modexp;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [W-1:0] base, exponent, modulus, result;
  logic         busy, done, error;

  always #5 clk = ~clk;

  rsa_modexp #(.W(W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .base(base), .exponent(exponent), .modulus(modulus),
    .busy(busy), .done(done), .result(result), .error(error)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  // Model state: one outstanding operation.
  bit          m_active = 1'b0;
  int          m_acc    = 0;
  int          m_lat    = 0;
  logic [31:0] m_res    = '0;
  logic [31:0] m_hres   = '0;
  bit          m_err    = 1'b0;
  bit          chk_en   = 1'b0;

  // Last observed done pulse.
  int          d_cnt = 0;
  int          d_cyc = 0;
  logic [31:0] d_res = '0;
  logic        d_err = 1'b0;

  function automatic logic [31:0] ref_modexp(input logic [31:0] b, input logic [31:0] e,
                                             input logic [31:0] n);
    longint unsigned r, x, nn;
    if (n <= 32'd1) return 32'd0;
    nn = longint'(n);
    r  = 1;
    x  = longint'(b) % nn;
    for (int i = 0; i < 32; i++) begin
      if (e[i]) r = (r * x) % nn;
      x = (x * x) % nn;
    end
    return 32'(r);
  endfunction

  function automatic int ref_latency(input logic [31:0] e, input logic [31:0] n);
    int k;
    if (n <= 32'd1) return 1;
    k = 0;
    for (int i = 0; i < 32; i++) if (e[i]) k = i + 1;
    return (k + 1) * (W + 1) + 1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    int          c;
    logic        eb, ed, ee;
    logic [31:0] er;
    if (chk_en) begin
      c  = cyc - m_acc;
      eb = m_active && c >= 1 && c < m_lat;
      ed = m_active && c == m_lat;
      er = (m_active && c >= m_lat) ? m_res : m_hres;
      ee = m_active && c >= m_lat && m_err;
      check("busy", 64'(busy), 64'(eb));
      check("done", 64'(done), 64'(ed));
      check("result", 64'(result), 64'(er));
      check("error", 64'(error), 64'(ee));
      if (done === 1'b1) begin
        d_cnt++;
        d_cyc = c;
        d_res = result;
        d_err = error;
      end
    end
  end

  // Pulse start for one edge; the model accepts it only when the DUT is idle.
  task automatic drive(input logic [31:0] b, input logic [31:0] e, input logic [31:0] n);
    int snap;
    bit acc;
    @(negedge clk);
    start    = 1'b1;
    base     = b;
    exponent = e;
    modulus  = n;
    snap     = cyc;
    acc      = !m_active || (snap >= m_acc + m_lat + 1);
    @(posedge clk);
    if (acc) begin
      if (m_active) m_hres = m_res;
      m_active = 1'b1;
      m_acc    = snap;
      m_lat    = ref_latency(e, n);
      m_res    = ref_modexp(b, e, n);
      m_err    = (n == 32'd0);
    end
    @(negedge clk);
    start    = 1'b0;
    base     = $urandom;
    exponent = $urandom;
    modulus  = $urandom;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!m_active || cyc >= m_acc + m_lat + 1) begin
        ok = 1'b1;
        break;
      end
    end
    check("wait_idle_timeout", 64'(ok), 64'(1));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    m_active = 1'b0;
    m_hres   = '0;
    chk_en   = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic directed(input logic [31:0] b, input logic [31:0] e, input logic [31:0] n,
                          input logic [31:0] er, input int ec, input logic ee);
    int dc;
    wait_idle();
    dc = d_cnt;
    drive(b, e, n);
    wait_idle();
    check("dir_done_count", 64'(d_cnt), 64'(dc + 1));
    check("dir_result", 64'(d_res), 64'(er));
    check("dir_done_cycle", 64'(d_cyc), 64'(ec));
    check("dir_error", 64'(d_err), 64'(ee));
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 90000", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int          dc;
    logic [31:0] rb, re, rn;
    int          sel;
    reset_n  = 1'b0;
    start    = 1'b0;
    base     = '0;
    exponent = '0;
    modulus  = '0;
    repeat (2) @(posedge clk);
    do_reset();

    // Pin the reference model with hand-computed values.
    check("pin_4_13_497", 64'(ref_modexp(32'd4, 32'd13, 32'd497)), 64'd445);
    check("pin_65_17_3233", 64'(ref_modexp(32'd65, 32'd17, 32'd3233)), 64'd2790);
    check("pin_2790_2753", 64'(ref_modexp(32'd2790, 32'd2753, 32'd3233)), 64'd65);
    check("pin_big", 64'(ref_modexp(32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFB)), 64'd16);
    check("pin_lat_13", 64'(ref_latency(32'd13, 32'd497)), 64'd166);

    // Directed cases with literal results and done cycles.
    directed(32'd4, 32'd13, 32'd497, 32'd445, 166, 1'b0);
    directed(32'd65, 32'd17, 32'd3233, 32'd2790, 199, 1'b0);
    directed(32'd2790, 32'd2753, 32'd3233, 32'd65, 430, 1'b0);
    directed(32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFB, 32'd16, 100, 1'b0);
    directed(32'd0, 32'd5, 32'd7, 32'd0, 133, 1'b0);
    directed(32'd3, 32'd0, 32'd7, 32'd1, 34, 1'b0);
    directed(32'd3, 32'd0, 32'd1, 32'd0, 1, 1'b0);
    directed(32'd3, 32'd0, 32'd0, 32'd0, 1, 1'b1);
    directed(32'd9, 32'd3, 32'd11, 32'd3, 100, 1'b0);

    // Start re-pulsed mid-operation is ignored.
    wait_idle();
    dc = d_cnt;
    drive(32'd65, 32'd17, 32'd3233);
    repeat (47) @(negedge clk);
    drive(32'd9, 32'd3, 32'd11);
    wait_idle();
    check("ignored_done_count", 64'(d_cnt), 64'(dc + 1));
    check("ignored_result", 64'(d_res), 64'd2790);
    check("ignored_done_cycle", 64'(d_cyc), 64'd199);

    // Reset during an operation abandons it without a done pulse.
    wait_idle();
    dc = d_cnt;
    drive(32'd4, 32'd13, 32'd497);
    repeat (38) @(negedge clk);
    do_reset();
    repeat (200) @(negedge clk);
    check("reset_no_done", 64'(d_cnt), 64'(dc));
    directed(32'd4, 32'd13, 32'd497, 32'd445, 166, 1'b0);

    // Randomized operations, sometimes with a stray start during the run.
    for (int it = 0; it < 30; it++) begin
      sel = $urandom_range(0, 9);
      rb  = $urandom;
      if (sel == 0)      rn = 32'($urandom_range(0, 1));
      else if (sel <= 2) rn = 32'($urandom_range(2, 40));
      else               rn = $urandom;
      if ($urandom_range(0, 4) == 0) re = 32'($urandom_range(0, 3));
      else                           re = $urandom >> $urandom_range(0, 31);
      wait_idle();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      drive(rb, re, rn);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 40)) @(negedge clk);
        drive($urandom, $urandom, $urandom);
      end
    end

    wait_idle();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rsa_modexp.md
Name: rsa_modexp

Overview:
- Modular exponentiation engine: computes result = base^exponent mod modulus on W-bit unsigned operands.
- Sits directly downstream of the modular-inverse stage. Its exponent port is driven from that stage's d output, and d_valid gates start. It performs RSA encrypt (exponent = e) and decrypt (exponent = d).
- Uses right-to-left binary square-and-multiply with two bit-serial interleaved modular multipliers running in parallel.

Parameters:
- W, 32, operand width in bits for base, exponent, modulus and result.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- reset_n  in  1  synchronous reset, active-low.
- start  in  1  request pulse; sampled only in IDLE.
- base  in  W  message or ciphertext; any value, reduced internally.
- exponent  in  W  e or d.
- modulus  in  W  n; unsigned.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when result is valid.
- result  out  W  base^exponent mod modulus; held until the next accepted start.
- error  out  1  set with done when modulus == 0; cleared on the next accepted start.

Behaviour:
- Reset (reset_n low at a clock edge): FSM goes to IDLE. busy=0, done=0, error=0, result=0.
  - Both multipliers are cleared and any in-flight operation is abandoned with no done.
  - Reset takes priority over every other event.
- States: IDLE, REDUCE, MULT, FIN.
- IDLE:
  - On start=1, latch base, exponent, modulus into internal registers. Inputs are don't-care afterwards.
  - If modulus == 0: go to FIN with result=0, error=1.
  - If modulus == 1: go to FIN with result=0, error=0.
  - Otherwise go to REDUCE.
- start while not IDLE: ignored; no effect on the current operation.
- REDUCE:
  - Launch multiplier A with (a=base, b=1), giving B = base mod n.
  - Set R=1. Wait for A done.
- MULT, one iteration per exponent bit, LSB first:
  - Launch A with (R, B) if e[0]=1; otherwise R is kept.
  - Launch B-multiplier with (B, B) in the same cycle.
  - On done: update R (if used) and B, then shift e right by 1.
- Loop control: after any multiplier done, if the shifted e == 0 go to FIN; else relaunch MULT in the next cycle.
- FIN: assert done for one cycle, drive result=R and error. busy drops in the same cycle. Return to IDLE.
- Multiplier timing:
  - Launch cycle L; iterations run in L+1..L+W; done in L+W.
  - The next launch is at L+W+1, so each op occupies W+1 cycles.
- Latency, with start sampled at cycle 0 and k = index of the exponent MSB + 1 (k=0 if exponent=0):
  - done at cycle (k+1)(W+1)+1. For W=32 this is 34 + 33k.
  - Fast paths (modulus ≤ 1): done at cycle 1.
- Exponent 0 with modulus ≥ 2: result = 1.
- Arithmetic, in sub-module mod_mult:
  - acc is W+2 bits, starts at 0. For i = W-1 down to 0: acc = 2·acc + (a[i] ? b : 0).
  - After each step, conditionally subtract n up to twice until acc < n.
  - Precondition b < n; it holds by construction because b=1 or b is already reduced.
  - No overflow is possible: 2acc + b < 3n < 2^(W+2).
- result < modulus always; no signed arithmetic anywhere.

Decomposition:
- Package rsa_pkg:
  - RSA_W localparam (32).
  - modexp_state_t enum {IDLE, REDUCE, MULT, FIN}.
  - mm_state_t enum {MM_IDLE, MM_RUN}.
  - Shared by the inverse stage and this block.
- Sub-module mod_mult:
  - Ports: clk, reset_n, start, a, b, n, p, done.
  - Bit-serial with a W-iteration counter, W+2-bit accumulator and two compare-subtract stages.
  - Instantiated twice (mm_r, mm_b).

Test Plan:
- base=4, exp=13, n=497 -> result=445, done exactly at cycle 166, busy high cycles 1..165, error=0.
- RSA toy key n=3233: base=65, exp=17 -> 2790; then base=2790, exp=2753 (d from the inverse stage with e=17, phi=3120) -> 65.
- base=0xFFFFFFFF, exp=2, n=0xFFFFFFFB -> result=16 (base reduces to 4); also base=0, exp=5, n=7 -> 0.
- exp=0, n=7, base=3 -> result=1 at cycle 34; n=1 -> result=0, done at cycle 1; n=0 -> error=1, result=0, done at cycle 1.
- start re-pulsed with different operands at cycle 50 of a running op -> ignored, original result delivered on schedule.
- reset_n low at cycle 40 of an op -> next cycle busy=0, done never pulses, result=0; a new start afterwards gives the correct answer.
